router_pkt_reg: RTL and testbench

- Datapath companion to the router control FSM in the 1x3 packet router.
- Consumes the FSM state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) and the input byte stream. Produces the byte written into the selected output FIFO.
- Holds back a byte that arrives while the FIFO is full and replays it afterwards.
- Computes the packet parity and returns the status flags the FSM needs: parity_done and low_pkt_valid. Also raises err on a parity mismatch.

---
 rtl/router_pkg.sv | 12 +
 rtl/router_parity_acc.sv | 67 ++++++
 rtl/router_pkt_reg.sv | 109 ++++++++++
 tb/tb_router_pkt_reg.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants for the 1x3 packet router: byte width, header address field and destinations.
package router_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_BITS  = 2;
  localparam logic [ADDR_BITS-1:0] INVALID_ADDR = 2'b11;

  typedef enum logic [ADDR_BITS-1:0] {
    DEST0 = 2'd0,
    DEST1 = 2'd1,
    DEST2 = 2'd2
  } dest_e;
endpackage

// File: rtl/router_parity_acc.sv
// Running packet parity, captured parity byte and sticky mismatch flag; 1-cycle registered.
// No backpressure of its own: follows the FSM strobes, skipping bytes that stall on fifo_full.
module router_parity_acc
  import router_pkg::*;
#(
  parameter int DW = router_pkg::DATA_WIDTH
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          dec_clr_i,
  input  logic          lfd_state_i,
  input  logic          ld_state_i,
  input  logic          laf_state_i,
  input  logic          pkt_valid_i,
  input  logic          fifo_full_i,
  input  logic          low_pkt_valid_i,
  input  logic          parity_done_i,
  input  logic [DW-1:0] data_in_i,
  input  logic [DW-1:0] hdr_i,
  input  logic [DW-1:0] hold_byte_i,
  output logic          err_o
);

  logic [DW-1:0] int_parity_q, int_parity_d;
  logic [DW-1:0] pkt_parity_q, pkt_parity_d;
  logic          err_q, err_d;

  always_comb begin
    int_parity_d = int_parity_q;
    if (dec_clr_i)
      int_parity_d = '0;
    else if (lfd_state_i)
      int_parity_d = int_parity_q ^ hdr_i;
    else if (ld_state_i && pkt_valid_i && !fifo_full_i)
      int_parity_d = int_parity_q ^ data_in_i;
    else if (laf_state_i && !low_pkt_valid_i)
      int_parity_d = int_parity_q ^ hold_byte_i;

    // A parity byte that stalled on full is recovered from the hold register.
    pkt_parity_d = pkt_parity_q;
    if (ld_state_i && !pkt_valid_i && !fifo_full_i)
      pkt_parity_d = data_in_i;
    else if (laf_state_i && low_pkt_valid_i)
      pkt_parity_d = hold_byte_i;

    err_d = err_q;
    if (dec_clr_i)
      err_d = 1'b0;
    else if (parity_done_i && (int_parity_q != pkt_parity_q))
      err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      int_parity_q <= '0;
      pkt_parity_q <= '0;
      err_q        <= 1'b0;
    end else begin
      int_parity_q <= int_parity_d;
      pkt_parity_q <= pkt_parity_d;
      err_q        <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/router_pkt_reg.sv
// Router datapath register: header capture, FIFO write byte with hold/replay on full, parity status.
// dout follows the sampled byte by 1 cycle; a byte arriving on fifo_full is parked and replayed in laf_state.
module router_pkt_reg
#(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
  parameter int ADDR_BITS  = router_pkg::ADDR_BITS,
  parameter logic [ADDR_BITS-1:0] INVALID_ADDR = router_pkg::INVALID_ADDR
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] dout
);
  import router_pkg::*;

  logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  parity_done_q, parity_done_d;
  logic                  low_pkt_valid_q, low_pkt_valid_d;
  logic                  bad_hdr;
  logic                  dec_clr;

  // An invalid header is ignored outright, so decode leaves all packet state untouched.
  assign bad_hdr = pkt_valid && (data_in[ADDR_BITS-1:0] == INVALID_ADDR);
  assign dec_clr = detect_add && !bad_hdr;

  always_comb begin
    hdr_d = hdr_q;
    if (detect_add && pkt_valid && !bad_hdr)
      hdr_d = data_in;

    dout_d = dout_q;
    hold_d = hold_q;
    if (!full_state) begin
      if (lfd_state)
        dout_d = hdr_q;
      else if (ld_state && !fifo_full)
        dout_d = data_in;
      else if (laf_state)
        dout_d = hold_q;

      if (ld_state && fifo_full)
        hold_d = data_in;
    end

    low_pkt_valid_d = low_pkt_valid_q;
    if (rst_int_reg)
      low_pkt_valid_d = 1'b0;
    else if (ld_state && !pkt_valid)
      low_pkt_valid_d = 1'b1;

    parity_done_d = parity_done_q;
    if (dec_clr)
      parity_done_d = 1'b0;
    else if ((ld_state && !fifo_full && !pkt_valid) ||
             (laf_state && low_pkt_valid_q && !parity_done_q))
      parity_done_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      hdr_q           <= '0;
      hold_q          <= '0;
      dout_q          <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
    end else begin
      hdr_q           <= hdr_d;
      hold_q          <= hold_d;
      dout_q          <= dout_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
    end
  end

  router_parity_acc #(.DW(DATA_WIDTH)) u_parity (
    .clock           (clock),
    .resetn          (resetn),
    .dec_clr_i       (dec_clr),
    .lfd_state_i     (lfd_state),
    .ld_state_i      (ld_state),
    .laf_state_i     (laf_state),
    .pkt_valid_i     (pkt_valid),
    .fifo_full_i     (fifo_full),
    .low_pkt_valid_i (low_pkt_valid_q),
    .parity_done_i   (parity_done_q),
    .data_in_i       (data_in),
    .hdr_i           (hdr_q),
    .hold_byte_i     (hold_q),
    .err_o           (err)
  );

  assign dout          = dout_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;

endmodule

// File: tb/tb_router_pkt_reg.sv
// Directed, table-driven check of router_pkt_reg against hand-computed outputs.
module tb_router_pkt_reg;

  logic       clock = 1'b0;
  logic       resetn, pkt_valid, fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] data_in, dout;
  logic       parity_done, low_pkt_valid, err;

  always #5 clock = ~clock;

  router_pkt_reg dut (
    .clock         (clock),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .err           (err),
    .dout          (dout)
  );

  localparam logic [5:0] IDL = 6'b000000;
  localparam logic [5:0] DA  = 6'b100000;
  localparam logic [5:0] LFD = 6'b010000;
  localparam logic [5:0] LD  = 6'b001000;
  localparam logic [5:0] LAF = 6'b000100;
  localparam logic [5:0] FUL = 6'b000010;
  localparam logic [5:0] RST = 6'b000001;

  typedef struct {
    logic       rstn;
    logic [5:0] st;
    logic       pv;
    logic       ff;
    logic [7:0] din;
    logic [7:0] edout;
    logic       epd;
    logic       elpv;
    logic       eerr;
  } vec_t;

  vec_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t v(input logic rstn, input logic [5:0] st, input logic pv,
                             input logic ff, input logic [7:0] din, input logic [7:0] edout,
                             input logic epd, input logic elpv, input logic eerr);
    vec_t r;
    r.rstn = rstn; r.st = st; r.pv = pv; r.ff = ff; r.din = din;
    r.edout = edout; r.epd = epd; r.elpv = elpv; r.eerr = eerr;
    return r;
  endfunction

  task automatic chk(input string nm, input string tag, input int idx,
                     input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] %s: got %h expected %h", tag, idx, nm, got, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string tag, input int idx);
    resetn = t.rstn;
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = t.st;
    pkt_valid = t.pv;
    fifo_full = t.ff;
    data_in   = t.din;
    @(posedge clock);
    #1;
    chk("dout",          tag, idx, dout,                 t.edout);
    chk("parity_done",   tag, idx, {7'd0, parity_done},   {7'd0, t.epd});
    chk("low_pkt_valid", tag, idx, {7'd0, low_pkt_valid}, {7'd0, t.elpv});
    chk("err",           tag, idx, {7'd0, err},           {7'd0, t.eerr});
  endtask

  task automatic run(input string tag);
    foreach (q[i]) apply(q[i], tag, i);
    q.delete();
  endtask

  initial begin
    // Reset, good packet 0D A1 22 37 / B9, bad-parity packet, invalid header.
    q.push_back(v(0, IDL, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    q.push_back(v(1, DA,  1, 0, 8'h0D, 8'h00, 0, 0, 0));
    q.push_back(v(1, LFD, 1, 0, 8'hA1, 8'h0D, 0, 0, 0));
    q.push_back(v(1, LD,  1, 0, 8'hA1, 8'hA1, 0, 0, 0));
    q.push_back(v(1, LD,  1, 0, 8'h22, 8'h22, 0, 0, 0));
    q.push_back(v(1, LD,  1, 0, 8'h37, 8'h37, 0, 0, 0));
    q.push_back(v(1, LD,  0, 0, 8'hB9, 8'hB9, 1, 1, 0));
    q.push_back(v(1, RST, 0, 0, 8'h00, 8'hB9, 1, 0, 0));
    q.push_back(v(1, IDL, 0, 0, 8'h00, 8'hB9, 1, 0, 0));
    q.push_back(v(1, DA,  1, 0, 8'h0D, 8'hB9, 0, 0, 0));
    q.push_back(v(1, LFD, 1, 0, 8'hA1, 8'h0D, 0, 0, 0));
    q.push_back(v(1, LD,  1, 0, 8'hA1, 8'hA1, 0, 0, 0));
    q.push_back(v(1, LD,  1, 0, 8'h22, 8'h22, 0, 0, 0));
    q.push_back(v(1, LD,  1, 0, 8'h37, 8'h37, 0, 0, 0));
    q.push_back(v(1, LD,  0, 0, 8'hB8, 8'hB8, 1, 1, 0));
    q.push_back(v(1, RST, 0, 0, 8'h00, 8'hB8, 1, 0, 1));
    q.push_back(v(1, IDL, 0, 0, 8'h00, 8'hB8, 1, 0, 1));
    q.push_back(v(1, DA,  1, 0, 8'h0D, 8'hB8, 0, 0, 0));
    q.push_back(v(1, DA,  1, 0, 8'h03, 8'hB8, 0, 0, 0));
    q.push_back(v(1, LFD, 1, 0, 8'hA1, 8'h0D, 0, 0, 0));
    q.push_back(v(1, IDL, 0, 0, 8'h00, 8'h0D, 0, 0, 0));
    run("table");

    // fifo_full on payload byte 22: A1 held through full_state, 22 replayed from laf_state.
    q.push_back(v(1, DA,  1, 0, 8'h0D, 8'h0D, 0, 0, 0));
    q.push_back(v(1, LFD, 1, 0, 8'hA1, 8'h0D, 0, 0, 0));
    q.push_back(v(1, LD,  1, 0, 8'hA1, 8'hA1, 0, 0, 0));
    q.push_back(v(1, LD,  1, 1, 8'h22, 8'hA1, 0, 0, 0));
    for (int k = 0; k < 3; k++) q.push_back(v(1, FUL, 1, 1, 8'h37, 8'hA1, 0, 0, 0));
    q.push_back(v(1, LAF, 1, 0, 8'h37, 8'h22, 0, 0, 0));
    q.push_back(v(1, LD,  1, 0, 8'h37, 8'h37, 0, 0, 0));
    q.push_back(v(1, LD,  0, 0, 8'hB9, 8'hB9, 1, 1, 0));
    q.push_back(v(1, RST, 0, 0, 8'h00, 8'hB9, 1, 0, 0));
    q.push_back(v(1, IDL, 0, 0, 8'h00, 8'hB9, 1, 0, 0));
    run("full_mid");

    // Reset after second payload byte, then clean packet 06 5A / 5C.
    q.push_back(v(1, DA,  1, 0, 8'h0D, 8'hB9, 0, 0, 0));
    q.push_back(v(1, LFD, 1, 0, 8'hA1, 8'h0D, 0, 0, 0));
    q.push_back(v(1, LD,  1, 0, 8'hA1, 8'hA1, 0, 0, 0));
    q.push_back(v(1, LD,  1, 0, 8'h22, 8'h22, 0, 0, 0));
    q.push_back(v(0, LD,  1, 0, 8'h37, 8'h00, 0, 0, 0));
    q.push_back(v(1, DA,  1, 0, 8'h06, 8'h00, 0, 0, 0));
    q.push_back(v(1, LFD, 1, 0, 8'h5A, 8'h06, 0, 0, 0));
    q.push_back(v(1, LD,  1, 0, 8'h5A, 8'h5A, 0, 0, 0));
    q.push_back(v(1, LD,  0, 0, 8'h5C, 8'h5C, 1, 1, 0));
    q.push_back(v(1, RST, 0, 0, 8'h00, 8'h5C, 1, 0, 0));
    q.push_back(v(1, IDL, 0, 0, 8'h00, 8'h5C, 1, 0, 0));
    run("rst_mid");

    // fifo_full on the parity byte: parity recovered in laf_state (previous pkt parity was 5C).
    q.push_back(v(1, DA,  1, 0, 8'h0D, 8'h5C, 0, 0, 0));
    q.push_back(v(1, LFD, 1, 0, 8'hA1, 8'h0D, 0, 0, 0));
    q.push_back(v(1, LD,  1, 0, 8'hA1, 8'hA1, 0, 0, 0));
    q.push_back(v(1, LD,  1, 0, 8'h22, 8'h22, 0, 0, 0));
    q.push_back(v(1, LD,  1, 0, 8'h37, 8'h37, 0, 0, 0));
    q.push_back(v(1, LD,  0, 1, 8'hB9, 8'h37, 0, 1, 0));
    q.push_back(v(1, FUL, 0, 1, 8'h00, 8'h37, 0, 1, 0));
    q.push_back(v(1, LAF, 0, 0, 8'h00, 8'hB9, 1, 1, 0));
    q.push_back(v(1, RST, 0, 0, 8'h00, 8'hB9, 1, 0, 0));
    q.push_back(v(1, IDL, 0, 0, 8'h00, 8'hB9, 1, 0, 0));
    q.push_back(v(1, IDL, 0, 0, 8'h00, 8'hB9, 1, 0, 0));
    run("full_par");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
